// File: rtl/mem_pkg.sv
// Shared types and helpers for the PicoRV32-side memory responder.
// Holds the responder FSM encoding and the byte-address range check.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } resp_state_t;

    localparam int WORD_BYTES = 4;

    // Unsigned, non-wrapping window test: base <= addr < base + WORD_BYTES*depth.
    function automatic logic in_range(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned depth
    );
        logic [32:0] span;
        logic [32:0] off;
        span = 33'(depth) * 33'(WORD_BYTES);
        off  = {1'b0, addr} - {1'b0, base};
        return (addr >= base) && (off < span);
    endfunction

endpackage

// File: rtl/bram_be.sv
// Single-port block RAM with per-byte write enables and a registered read port.
module bram_be import mem_pkg::*; #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS),
  parameter string       INIT_FILE   = ""
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // NOTE: the array is deliberately left out of any reset so the tools can map it onto block RAM.
  always_ff @(posedge clk) begin
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (we[b]) begin
        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Word-addressed RAM target for the PicoRV32 native memory bus: one request at a
// time, programmable wait states, single-cycle mem_ready, sticky out-of-range flag.
module mem_responder import mem_pkg::*; #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        err
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    resp_state_t   state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic          ready_q, ready_d;
    logic          rd_ok_q, rd_ok_d;
    logic          err_q, err_d;

    logic          addr_ok;
    logic [AW-1:0] word_idx;
    logic [3:0]    ram_we;
    logic [31:0]   ram_rdata;
    logic          unused_instr;

    assign unused_instr = mem_instr;
    assign addr_ok      = in_range(addr_q, BASE_ADDR, DEPTH_WORDS);
    assign word_idx     = AW'((addr_q - BASE_ADDR) >> 2);

    // A reset on the RESP edge must suppress the commit as well as the handshake.
    assign ram_we = (state_q == RESP && reset_n && addr_ok) ? wstrb_q : 4'b0000;

    bram_be #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW),
        .INIT_FILE   (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (word_idx),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // NOTE: every signal gets a default before the case so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        ready_d = 1'b0;
        rd_ok_d = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!mem_valid) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                ready_d = 1'b1;
                rd_ok_d = addr_ok && (wstrb_q == 4'b0000);
                err_d   = err_q | ~addr_ok;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments let every flop sample the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            ready_q <= 1'b0;
            rd_ok_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            ready_q <= ready_d;
            rd_ok_q <= rd_ok_d;
            err_q   <= err_d;
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rd_ok_q ? ram_rdata : 32'd0;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder at three wait-state settings (0, 1, 3).
// A word-array model predicts read data, err and the exact mem_ready cycle.
module tb_mem_responder;

    localparam int          NI    = 3;
    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    function automatic int wait_of(input int k);
        return (k == 0) ? 0 : (k == 1) ? 1 : 3;
    endfunction

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic              clk = 1'b0;
    logic [NI-1:0]     reset_n;
    logic [NI-1:0]     mem_valid;
    logic [NI-1:0]     mem_instr;
    logic [NI-1:0]     mem_ready;
    logic [NI-1:0]     err;
    logic [31:0]       mem_addr  [NI];
    logic [31:0]       mem_wdata [NI];
    logic [31:0]       mem_rdata [NI];
    logic [3:0]        mem_wstrb [NI];

    logic [31:0]       ref_mem [NI][DEPTH];
    logic [NI-1:0]     ref_err;
    exp_t              sb [NI][$];
    exp_t              mon_e;
    int                cyc = 0;
    int                n_cmp = 0;
    int                n_fail = 0;

    logic [31:0] pool [10] = '{32'h0000_0000, 32'h0000_0004, 32'h0000_0010, 32'h0000_0020,
                               32'h0000_0030, 32'h0000_0FFC, 32'h0000_1000, 32'h0000_1004,
                               32'hFFFF_FFF0, 32'h8000_0000};

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_responder #(
            .DEPTH_WORDS (DEPTH),
            .BASE_ADDR   (BASE),
            .WAIT_CYCLES (wait_of(g)),
            .INIT_FILE   ("")
        ) u_dut (
            .clk       (clk),
            .reset_n   (reset_n[g]),
            .mem_valid (mem_valid[g]),
            .mem_instr (mem_instr[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_wstrb (mem_wstrb[g]),
            .mem_ready (mem_ready[g]),
            .mem_rdata (mem_rdata[g]),
            .err       (err[g])
        );
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp_v);
        end
    endtask

    // Reference access: range test and byte merge done with plain arithmetic on a word array.
    function automatic exp_t model_access(input int k, input logic [31:0] a,
                                          input logic [31:0] d, input logic [3:0] s);
        exp_t            e;
        longint unsigned la, lb, lim;
        int              idx;
        la  = longint'(a);
        lb  = longint'(BASE);
        lim = lb + 64'(4 * DEPTH);
        e.cyc   = 0;
        e.rdata = 32'd0;
        if (la >= lb && la < lim) begin
            idx = int'((la - lb) / 4);
            if (s == 4'd0) begin
                e.rdata = ref_mem[k][idx];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (s[b]) ref_mem[k][idx][8*b +: 8] = d[8*b +: 8];
                end
            end
        end else begin
            ref_err[k] = 1'b1;
        end
        e.err = ref_err[k];
        return e;
    endfunction

    task automatic scramble(input int k);
        mem_addr[k]  = $urandom;
        mem_wdata[k] = $urandom;
        mem_wstrb[k] = 4'($urandom);
        mem_instr[k] = 1'($urandom);
    endtask

    // One complete transaction; inputs are scrambled after acceptance to prove they are latched.
    task automatic txn(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int   w;
        exp_t e;
        w = wait_of(k);
        mem_valid[k] = 1'b1;
        mem_addr[k]  = a;
        mem_wdata[k] = d;
        mem_wstrb[k] = s;
        mem_instr[k] = 1'($urandom);
        e = model_access(k, a, d, s);
        e.cyc = cyc + w + 2;
        sb[k].push_back(e);
        @(posedge clk); #1;
        scramble(k);
        repeat (w) begin
            @(posedge clk); #1;
            scramble(k);
        end
        mem_valid[k] = 1'b0;
        @(posedge clk); #1;
    endtask

    // mem_valid held high with constant inputs: a new read is accepted every w+2 cycles.
    task automatic burst(input int k, input logic [31:0] a, input int n);
        int   w;
        exp_t e;
        w = wait_of(k);
        mem_valid[k] = 1'b1;
        mem_addr[k]  = a;
        mem_wdata[k] = $urandom;
        mem_wstrb[k] = 4'd0;
        for (int i = 0; i < n; i++) begin
            e = model_access(k, a, 32'd0, 4'd0);
            e.cyc = cyc + 1 + i * (w + 2) + w + 1;
            sb[k].push_back(e);
        end
        repeat (n * (w + 2)) @(posedge clk);
        #1;
        mem_valid[k] = 1'b0;
    endtask

    task automatic abort_wr(input int k, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int j);
        mem_valid[k] = 1'b1;
        mem_addr[k]  = a;
        mem_wdata[k] = d;
        mem_wstrb[k] = s;
        @(posedge clk); #1;
        repeat (j) begin
            @(posedge clk); #1;
        end
        mem_valid[k] = 1'b0;
        repeat (wait_of(k) + 3) @(posedge clk);
        #1;
    endtask

    task automatic rst_mid(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        mem_valid[k] = 1'b1;
        mem_addr[k]  = a;
        mem_wdata[k] = d;
        mem_wstrb[k] = s;
        @(posedge clk); #1;
        reset_n[k]   = 1'b0;
        mem_valid[k] = 1'b0;
        @(posedge clk); #1;
        reset_n[k] = 1'b1;
        ref_err[k] = 1'b0;
        check($sformatf("rst_mid_err[%0d]", k), 32'(err[k]), 32'd0);
        check($sformatf("rst_mid_ready[%0d]", k), 32'(mem_ready[k]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_suite(input int k);
        int          w;
        int          pick;
        logic [31:0] a;
        logic [3:0]  s;
        w = wait_of(k);
        txn(k, 32'h0000_0000, 32'h0000_006F, 4'hF);
        txn(k, 32'h0000_0000, 32'h0, 4'h0);
        txn(k, 32'h0000_0004, $urandom, 4'hF);
        txn(k, 32'h0000_0010, 32'h0, 4'hF);
        txn(k, 32'h0000_0020, 32'h1234_5678, 4'hF);
        txn(k, 32'h0000_0030, 32'hCAFE_F00D, 4'hF);
        txn(k, 32'h0000_0FFC, $urandom, 4'hF);
        txn(k, 32'h0000_0010, 32'hDEAD_BEEF, 4'b0101);
        txn(k, 32'h0000_0010, 32'h0, 4'h0);
        burst(k, 32'h0000_0000, 3);
        txn(k, 32'h0000_1000, 32'h0, 4'h0);
        txn(k, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF);
        txn(k, 32'h0000_0000, 32'h0, 4'h0);
        txn(k, 32'h0000_0FFC, 32'h0, 4'h0);
        if (w > 0) begin
            abort_wr(k, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF, $urandom_range(0, w - 1));
            txn(k, 32'h0000_0020, 32'h0, 4'h0);
        end
        rst_mid(k, 32'h0000_0030, 32'hFFFF_FFFF, 4'hF);
        txn(k, 32'h0000_0030, 32'h0, 4'h0);
        for (int i = 0; i < 40; i++) begin
            a    = pool[$urandom_range(0, 9)] | 32'($urandom_range(0, 3));
            s    = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
            pick = $urandom_range(0, 9);
            if (pick == 0 && w > 0) begin
                abort_wr(k, a, $urandom, 4'hF, $urandom_range(0, w - 1));
            end else if (pick == 1) begin
                burst(k, a, 2);
            end else if (pick == 2) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end else begin
                txn(k, a, $urandom, s);
            end
        end
    endtask

    // Monitor: a due record must see mem_ready with the predicted data; otherwise the bus is quiet.
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (sb[k].size() > 0 && sb[k][0].cyc == cyc) begin
                mon_e = sb[k].pop_front();
                check($sformatf("ready[%0d]@%0d", k, cyc), 32'(mem_ready[k]), 32'd1);
                check($sformatf("rdata[%0d]@%0d", k, cyc), mem_rdata[k], mon_e.rdata);
                check($sformatf("err[%0d]@%0d", k, cyc), 32'(err[k]), 32'(mon_e.err));
            end else begin
                check($sformatf("idle_ready[%0d]@%0d", k, cyc), 32'(mem_ready[k]), 32'd0);
                check($sformatf("idle_rdata[%0d]@%0d", k, cyc), mem_rdata[k], 32'd0);
            end
        end
    end

    initial begin
        reset_n   = '0;
        mem_valid = '0;
        mem_instr = '0;
        ref_err   = '0;
        for (int k = 0; k < NI; k++) begin
            mem_addr[k]  = 32'd0;
            mem_wdata[k] = 32'd0;
            mem_wstrb[k] = 4'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("reset_ready[%0d]", k), 32'(mem_ready[k]), 32'd0);
            check($sformatf("reset_rdata[%0d]", k), mem_rdata[k], 32'd0);
            check($sformatf("reset_err[%0d]", k), 32'(err[k]), 32'd0);
        end
        reset_n = '1;
        @(posedge clk); #1;
        for (int k = 0; k < NI; k++) begin
            run_suite(k);
        end
        repeat (10) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("pending_responses[%0d]", k), 32'(sb[k].size()), 32'd0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
